// File: rtl/dmem_arbiter_rv32i.sv
// Two-port round-robin arbiter in front of a single-ported RV32I data memory.
// Serves one transaction at a time through IDLE -> ACCESS -> RESP.
module dmem_arbiter_rv32i #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [1:0]  a_type,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic [1:0]  b_type,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_rsp_valid,
    output logic        b_rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_store,
    output logic [1:0]  mem_storetype,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        acc_err;

    assign acc_err = (type_q == 2'b11)
                  || (addr_q >= ADDR_LIMIT)
                  || ((type_q == 2'b00) && (addr_q[1:0] != 2'b00))
                  || ((type_q == 2'b01) && addr_q[0]);

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        port_d        = port_q;
        we_d          = we_q;
        type_d        = type_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        a_ready       = 1'b0;
        b_ready       = 1'b0;
        a_rsp_valid   = 1'b0;
        b_rsp_valid   = 1'b0;
        mem_store     = 1'b0;
        mem_storetype = 2'b00;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        case (state_q)
            ST_IDLE: begin
                // ptr_q = 1 means B wins a tie
                a_ready = reset_n && a_valid && (!b_valid || !ptr_q);
                b_ready = reset_n && b_valid && (!a_valid || ptr_q);
                if (a_ready || b_ready) begin
                    port_d  = b_ready;
                    ptr_d   = !b_ready;
                    we_d    = b_ready ? b_we    : a_we;
                    type_d  = b_ready ? b_type  : a_type;
                    addr_d  = b_ready ? b_addr  : a_addr;
                    wdata_d = b_ready ? b_wdata : a_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_store     = we_q && !acc_err;
                mem_storetype = type_q;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                err_d         = acc_err;
                rdata_d       = (we_q || acc_err) ? 32'h0 : mem_rdata;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                a_rsp_valid = !port_q;
                b_rsp_valid = port_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            port_q  <= port_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: doc/dmem_arbiter_rv32i.md
DMEM_ARBITER_RV32I -- requirements
Module: dmem_arbiter_rv32i

Interface
REQ-001 Parameter: ADDR_LIMIT, default 32'h0000_0400, first illegal byte address (256 x 32-bit data memory).
REQ-002 clock  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset is synchronous and active-low.
REQ-004 a_valid / b_valid  in  1  request valid, port A (CPU load/store) / port B (debug/DMA).
REQ-005 a_ready / b_ready  out  1  request accepted when valid & ready are both high at a rising edge.
REQ-006 a_we / b_we  in  1  1=store, 0=load.
REQ-007 a_type / b_type  in  2  00=word, 01=half, 10=byte, 11=illegal.
REQ-008 a_addr / b_addr  in  32  byte address.
REQ-009 a_wdata / b_wdata  in  32  store data, right-aligned.
REQ-010 a_rsp_valid / b_rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  32  shared raw word read, valid with either rsp_valid.
REQ-012 rsp_err  out  1  shared error flag, valid with either rsp_valid.
REQ-013 mem_store  out  1  data memory write enable.
REQ-014 mem_storetype  out  2  data memory store type.
REQ-015 mem_addr  out  32  data memory byte address.
REQ-016 mem_wdata  out  32  data memory write data (rs2).
REQ-017 mem_rdata  in  32  data memory asynchronous read data.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP always, RESP->IDLE always.
REQ-019 Exactly one transaction in flight; a_ready and b_ready low in ACCESS and RESP.
REQ-020 In IDLE, only one valid port: that port's ready high, combinationally.
REQ-021 In IDLE, both valid: grant per round-robin pointer; other ready low.
REQ-022 Pointer (reset = port A) flips to the non-granted port on each acceptance.
REQ-023 Accepted we, type, addr, wdata, and port ID latched at acceptance edge; requester may change inputs afterwards.
REQ-024 Error if type=11, or addr >= ADDR_LIMIT, or word with addr[1:0]!=0, or half with addr[0]=1.
REQ-025 Error check evaluated on latched values; result held in register through RESP.
REQ-026 ACCESS: mem_addr, mem_storetype, mem_wdata = latched values; mem_store = latched we & ~error.
REQ-027 Outside ACCESS: mem_store=0; mem_addr, mem_storetype, mem_wdata = 0.
REQ-028 Memory writes at falling edge inside ACCESS; arbiter adds no further write timing.
REQ-029 Load: mem_rdata sampled into rsp_rdata at rising edge ending ACCESS; no shift, no sign extension.
REQ-030 Store or error: rsp_rdata = 0.
REQ-031 Error: rsp_err=1, no memory write issued.
REQ-032 RESP: only the granted port's rsp_valid high for exactly one cycle.
REQ-033 Latency: accept at edge N, mem_store high cycle N..N+1, rsp_valid high cycle N+1..N+2, ready again in IDLE from N+2.
REQ-034 Peak throughput: one transaction per 3 cycles; continuously valid ports alternate A,B,A,B.
REQ-035 Request dropped (valid falls) before acceptance: no effect on state or pointer.

Reset
REQ-036 reset_n low at rising edge: state=IDLE, pointer=A, all latches 0.
REQ-037 During reset: all outputs 0, both ready low.
REQ-038 Reset sampled during ACCESS: falling-edge write of that cycle completes, no response issued for it.
REQ-039 First acceptance possible at the first rising edge with reset_n high.

Verification
REQ-040 Reset, then A store word addr 0x10 data 0xDEADBEEF -> mem_store high one cycle with mem_addr=0x10, mem_wdata=0xDEADBEEF; a_rsp_valid pulse 1 cycle later, rsp_err=0, rsp_rdata=0.
REQ-041 Memory word 0x10 = 0xDEADBEEF, B load word 0x10 -> b_rsp_valid with rsp_rdata=0xDEADBEEF, a_rsp_valid stays 0.
REQ-042 A and B continuously valid for 4 transactions after reset -> grant order A,B,A,B; accepts exactly 3 cycles apart.
REQ-043 Errors: A store word 0x12, store half 0x11, type 11, and store byte 0x400 -> each rsp_err=1, mem_store never high.
REQ-044 reset_n low in ACCESS of an A store -> no a_rsp_valid; after release state IDLE, pointer A, B-only request granted immediately.
